// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding word request, a single holding
// register toward the instruction register, redirect and delivery counting.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectAddr,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic        we,
  output logic [31:0] instrOUT,
  output logic [31:0] addrOUT,
  output logic [31:0] fetchCount
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_addr;
  logic [31:0] r_count;

  logic        w_xfer;
  logic [31:0] w_redir_pc;

  // Fetch addresses are always word-aligned, so low bits are dropped here.
  assign w_redir_pc = {redirectAddr[31:2], 2'b00};
  // A delivery happens only when a held word is offered and downstream takes it.
  assign w_xfer     = we && !stall;

  assign memReq     = (r_state == S_FETCH) && !rst;
  assign memAddr    = r_pc;
  assign we         = (r_state == S_HOLD) && !redirect && !rst;
  assign instrOUT   = r_instr;
  assign addrOUT    = r_addr;
  assign fetchCount = r_count;

  // FSM, pc, holding register and delivery counter; reset beats redirect beats all else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_instr <= 32'h0;
      r_addr  <= 32'h0;
      r_count <= 32'h0;
    end else if (redirect) begin
      // Aborts a pending request or discards a held word; no count change.
      r_state <= S_FETCH;
      r_pc    <= w_redir_pc;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (memAck) begin
            r_instr <= memData;
            r_addr  <= r_pc;
            r_pc    <= r_pc + 32'd4;
            r_state <= S_HOLD;
          end
        end
        default: begin
          // memAck is ignored while holding; only a transfer releases HOLD.
          if (w_xfer) begin
            r_state <= S_FETCH;
            r_count <= r_count + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: stimulus pushes expected deliveries into a
// queue, a negedge monitor pops and compares on each transfer, and the
// stimulus thread also checks control outputs directly.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, memAck;
  logic [31:0] redirectAddr, memData;
  logic        memReq, we;
  logic [31:0] memAddr, instrOUT, addrOUT, fetchCount;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  ifetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirectAddr(redirectAddr), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .we(we), .instrOUT(instrOUT),
    .addrOUT(addrOUT), .fetchCount(fetchCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected delivery.
  always @(negedge clk) begin
    if (we === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got instr %h addr %h expected no transfer", instrOUT, addrOUT);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_instr", instrOUT, e[63:32]);
        chk("sb_addr",  addrOUT,  e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; memAck = 1'b0;
    redirectAddr = 32'h0; memData = 32'h0;
    step(); step();
    samp();
    chk("rst_memReq", {31'h0, memReq}, 32'h0);
    chk("rst_we",     {31'h0, we},     32'h0);
    chk("rst_count",  fetchCount, 32'h0);
    chk("rst_instr",  instrOUT,   32'h0);

    // Basic fetch and delivery
    step();
    rst = 1'b0; memAck = 1'b1; memData = 32'hDEADBEEF;
    exp_q.push_back({32'hDEADBEEF, 32'h0});
    samp();
    chk("f1_memReq", {31'h0, memReq}, 32'h1);
    chk("f1_memAddr", memAddr, 32'h0);
    step();
    memAck = 1'b0;
    samp();
    chk("f1_we",    {31'h0, we}, 32'h1);
    chk("f1_instr", instrOUT, 32'hDEADBEEF);
    chk("f1_addr",  addrOUT,  32'h0);
    step();
    samp();
    chk("f1_next_addr", memAddr, 32'h4);
    chk("f1_count",     fetchCount, 32'h1);
    chk("f1_we_low",    {31'h0, we}, 32'h0);

    // Stall in HOLD for 3 cycles; memAck during HOLD is ignored
    memAck = 1'b1; memData = 32'h11111111; stall = 1'b1;
    exp_q.push_back({32'h11111111, 32'h4});
    step();
    memData = 32'h22222222;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("st_we",     {31'h0, we},     32'h1);
      chk("st_memReq", {31'h0, memReq}, 32'h0);
      chk("st_instr",  instrOUT,   32'h11111111);
      chk("st_count",  fetchCount, 32'h1);
      step();
    end
    stall = 1'b0; memAck = 1'b0;
    samp();
    step();
    samp();
    chk("st_count_after", fetchCount, 32'h2);
    chk("st_memAddr",     memAddr,    32'h8);
    chk("st_memReq_after", {31'h0, memReq}, 32'h1);

    // Redirect in FETCH without ack
    redirect = 1'b1; redirectAddr = 32'h100;
    step();
    redirect = 1'b0;
    samp();
    chk("rd1_memAddr", memAddr, 32'h100);
    chk("rd1_we",      {31'h0, we}, 32'h0);

    // Redirect on the same edge as memAck: data dropped
    redirect = 1'b1; redirectAddr = 32'h200; memAck = 1'b1; memData = 32'hBAD0BAD0;
    step();
    redirect = 1'b0; memAck = 1'b0;
    samp();
    chk("rd2_we",      {31'h0, we}, 32'h0);
    chk("rd2_memAddr", memAddr,     32'h200);
    chk("rd2_count",   fetchCount,  32'h2);
    step();
    samp();
    chk("rd2_we_later", {31'h0, we}, 32'h0);

    // Unaligned redirect, then wrap of pc past 32'hFFFFFFFC
    redirect = 1'b1; redirectAddr = 32'h103;
    step();
    redirect = 1'b0;
    samp();
    chk("al_memAddr", memAddr, 32'h100);
    redirect = 1'b1; redirectAddr = 32'hFFFFFFFF;
    step();
    redirect = 1'b0;
    samp();
    chk("wr_memAddr", memAddr, 32'hFFFFFFFC);
    memAck = 1'b1; memData = 32'hCAFEF00D;
    exp_q.push_back({32'hCAFEF00D, 32'hFFFFFFFC});
    step();
    memAck = 1'b0;
    samp();
    chk("wr_we", {31'h0, we}, 32'h1);
    step();
    samp();
    chk("wr_memAddr_next", memAddr, 32'h0);
    chk("wr_count",        fetchCount, 32'h3);

    // Redirect in HOLD discards the held word
    memAck = 1'b1; memData = 32'h12345678;
    step();
    memAck = 1'b0; redirect = 1'b1; redirectAddr = 32'h40;
    samp();
    chk("rh_we",    {31'h0, we}, 32'h0);
    chk("rh_instr", instrOUT, 32'h12345678);
    step();
    redirect = 1'b0;
    samp();
    chk("rh_memAddr", memAddr,    32'h40);
    chk("rh_count",   fetchCount, 32'h3);
    chk("rh_instr_kept", instrOUT, 32'h12345678);
    chk("rh_addr_kept",  addrOUT,  32'h0);

    // Reset while stalled in HOLD
    memAck = 1'b1; memData = 32'h55555555; stall = 1'b1;
    step();
    memAck = 1'b0; rst = 1'b1;
    samp();
    chk("rh2_we",     {31'h0, we},     32'h0);
    chk("rh2_memReq", {31'h0, memReq}, 32'h0);
    step();
    rst = 1'b0; stall = 1'b0;
    samp();
    chk("rr_memAddr", memAddr,    32'h0);
    chk("rr_instr",   instrOUT,   32'h0);
    chk("rr_addr",    addrOUT,    32'h0);
    chk("rr_count",   fetchCount, 32'h0);
    chk("rr_memReq",  {31'h0, memReq}, 32'h1);
    chk("rr_we",      {31'h0, we},     32'h0);

    step(); step();
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, word-aligned fetch address loaded on reset.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port stall  input  1  downstream not ready; blocks transfer to the instruction register.
REQ-006 SHALL have port redirect  input  1  one-cycle request to restart fetch at redirectAddr.
REQ-007 SHALL have port redirectAddr  input  32  new fetch address.
REQ-008 SHALL have port memReq  output  1  instruction-memory read request.
REQ-009 SHALL have port memAddr  output  32  read address, always word-aligned.
REQ-010 SHALL have port memAck  input  1  memory returns memData this cycle.
REQ-011 SHALL have port memData  input  32  fetched instruction word.
REQ-012 SHALL have port we  output  1  write enable to the instruction register.
REQ-013 SHALL have port instrOUT  output  32  instruction presented to the instruction register.
REQ-014 SHALL have port addrOUT  output  32  address of instrOUT.
REQ-015 SHALL have port fetchCount  output  32  count of delivered instructions.

Function
REQ-016 SHALL implement a two-state FSM: FETCH (request outstanding) and HOLD (instruction held for delivery).
REQ-017 In FETCH: memReq=1, memAddr=pc; memAddr stays stable until memAck or redirect.
REQ-018 On an edge in FETCH with memAck=1 and redirect=0: instrOUT<=memData, addrOUT<=pc, pc<=pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), state<=HOLD.
REQ-019 In HOLD: memReq=0; instrOUT and addrOUT stay stable.
REQ-020 SHALL drive we combinationally as (state==HOLD) && !redirect && !rst.
REQ-021 A transfer occurs on an edge with we=1 and stall=0: state<=FETCH, fetchCount<=fetchCount+1 (wraps).
REQ-022 While stall=1 in HOLD: we stays 1, the FSM stays in HOLD, and no memory request is issued.
REQ-023 Redirect has priority over all events except rst: pc<=redirectAddr with bits [1:0] forced to 0, state<=FETCH.
REQ-024 Redirect in FETCH SHALL abort the outstanding request; memData on that edge is discarded even if memAck=1.
REQ-025 Redirect in HOLD SHALL discard the held instruction with no transfer; fetchCount is unchanged and instrOUT/addrOUT keep their values.
REQ-026 memAck in HOLD SHALL be ignored.
REQ-027 Latency: memAck at edge N gives we=1 during cycle N+1; with stall=0, memReq is reasserted in cycle N+2 at pc+4.

Reset
REQ-028 On an edge with rst=1: pc<=RESET_PC, state<=FETCH, instrOUT<=0, addrOUT<=0, fetchCount<=0.
REQ-029 While rst=1: memReq=0 and we=0; rst overrides redirect, memAck and stall on the same edge.
REQ-030 Reset mid-HOLD or mid-FETCH SHALL drop any held or pending instruction.

Verification
REQ-031 Reset, then memAck=1 with memData=32'hDEADBEEF in the first FETCH cycle -> memAddr=0; next cycle we=1, instrOUT=32'hDEADBEEF, addrOUT=0; after transfer, memAddr=4 and fetchCount=1.
REQ-032 stall=1 for 3 cycles in HOLD -> we=1 and memReq=0 throughout, instrOUT stable, fetchCount unchanged; on release, one transfer.
REQ-033 redirect=1 with redirectAddr=32'h100 while in FETCH with no memAck -> next cycle memAddr=32'h100, we=0.
REQ-034 redirect (redirectAddr=32'h200) on the same edge as memAck -> data dropped, no we pulse, next memAddr=32'h200, fetchCount unchanged.
REQ-035 redirectAddr=32'h103 -> memAddr=32'h100; pc=32'hFFFFFFFC with memAck and transfer -> next memAddr=0.
REQ-036 rst asserted in HOLD with stall=1 -> we=0 immediately; after release, memAddr=RESET_PC, instrOUT=0, fetchCount=0.
